cache_controller: RTL and testbench

Sequencing controller for the core's direct-mapped data-cache array. It owns the tag/valid store and decodes CPU load/store requests into hit/miss. On a read miss it refills a full line from main memory over a request/acknowledge handshake. Stores are written through to memory, updating the array only on a hit. It sits between the CPU memory stage, the cache data array and the main-memory port.

---
 rtl/cache_controller.sv | 184 ++++++++++++++++++
 tb/tb_cache_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller
// Sequencing controller for a direct-mapped, write-through data cache.
// Owns the tag/valid store, decodes CPU loads/stores into hit/miss, refills
// a full line from main memory on a read miss, and writes every store
// through to memory (updating the data array only when the line is present).
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   cpu_req/we/addr/wdata     CPU request, held until cpu_ready
//   cpu_rdata, cpu_ready      load data and access-complete strobe
//   data_addr/we/wdata/rdata  data-array port, word address {index, offset}
//   mem_req/we/addr/wdata     main-memory request, held until mem_ack
//   mem_rdata, mem_ack        main-memory response
//   hit_count, miss_count     read hit/miss counters (CACHE_STATS_EN only)
//
// Optional feature: define CACHE_STATS_EN to add the hit/miss counters.
module cache_controller #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_SETS        = 16,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         cpu_req,
  input  logic                                         cpu_we,
  input  logic [ADDR_WIDTH-1:0]                        cpu_addr,
  input  logic [DATA_WIDTH-1:0]                        cpu_wdata,
  output logic [DATA_WIDTH-1:0]                        cpu_rdata,
  output logic                                         cpu_ready,
  output logic [$clog2(NUM_SETS*WORDS_PER_BLOCK)-1:0]  data_addr,
  output logic                                         data_we,
  output logic [DATA_WIDTH-1:0]                        data_wdata,
  input  logic [DATA_WIDTH-1:0]                        data_rdata,
  output logic                                         mem_req,
  output logic                                         mem_we,
  output logic [ADDR_WIDTH-1:0]                        mem_addr,
  output logic [DATA_WIDTH-1:0]                        mem_wdata,
  input  logic [DATA_WIDTH-1:0]                        mem_rdata,
  input  logic                                         mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                                  hit_count,
  output logic [31:0]                                  miss_count
`endif
);

  localparam int OB = $clog2(WORDS_PER_BLOCK);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TB = ADDR_WIDTH - IB - OB - 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;

  localparam logic [OB-1:0] W_LAST = {OB{1'b1}};

  logic [1:0]          state;
  logic [OB-1:0]       w;
  logic [NUM_SETS-1:0] valid;
  logic [TB-1:0]       tag_store [NUM_SETS];

  logic [OB-1:0] offset;
  logic [IB-1:0] index;
  logic [TB-1:0] tag;
  logic          hit;
  logic          refill_done;
  logic          unused_byte_bits;

  assign offset = cpu_addr[OB+1:2];
  assign index  = cpu_addr[OB+IB+1:OB+2];
  assign tag    = cpu_addr[ADDR_WIDTH-1:OB+IB+2];
  assign hit    = valid[index] && (tag_store[index] == tag);
  // Byte lane bits are not used: every access is a full word.
  assign unused_byte_bits = ^cpu_addr[1:0];

  assign refill_done = (state == REFILL) && mem_ack && (w == W_LAST);

  always_comb begin
    cpu_rdata  = '0;
    cpu_ready  = 1'b0;
    data_addr  = {index, offset};
    data_we    = 1'b0;
    data_wdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (cpu_req && !cpu_we && hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = data_rdata;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag, index, w, 2'b00};
        if (mem_ack) begin
          data_we    = 1'b1;
          data_addr  = {index, w};
          data_wdata = mem_rdata;
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata = cpu_wdata;
        if (mem_ack) begin
          cpu_ready = 1'b1;
          // Write-through with no allocate: only a present line is updated.
          if (hit) begin
            data_we    = 1'b1;
            data_wdata = cpu_wdata;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      valid <= '0;
      w     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              state <= WRITE;
            end else if (!hit) begin
              state <= REFILL;
              w     <= '0;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            w <= w + 1'b1;
            // Valid is raised only once the whole line has arrived.
            if (w == W_LAST) begin
              valid[index] <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && refill_done) tag_store[index] <= tag;
  end

`ifdef CACHE_STATS_EN
  // Set on a miss so the re-evaluated hit that completes it is not counted.
  logic refilled;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      refilled   <= 1'b0;
    end else if (state == IDLE && cpu_req && !cpu_we) begin
      if (!hit) begin
        refilled <= 1'b1;
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end else if (refilled) begin
        refilled <= 1'b0;
      end else if (hit_count != 32'hFFFF_FFFF) begin
        hit_count <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a queue scoreboard: expected
// memory transfers and CPU completions are queued when a request is driven
// and retired by monitors when the DUT performs them.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [5:0]  data_addr;
  logic        data_we;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int wait_cnt = 0;
  int acks_seen = 0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } mem_t;

  typedef struct {
    logic        we;
    logic [31:0] data;
    logic        dwe;
    logic [5:0]  daddr;
  } cpu_t;

  mem_t exp_mem[$];
  cpu_t exp_cpu[$];

  logic [31:0] mem_model [1024];
  logic [31:0] darr [64];

  cache_controller dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .data_addr(data_addr), .data_we(data_we), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // Data array with combinational read; main memory backing store.
  assign data_rdata = darr[data_addr];

  always @(posedge clk) begin
    if (data_we) darr[data_addr] <= data_wdata;
    if (mem_req && mem_we && mem_ack) mem_model[mem_addr[11:2]] <= mem_wdata;
  end

  // Memory responder: acks after `lat` wait cycles, so lat = 0 acks in the
  // first request cycle and back-to-back acks occur during a refill.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_model[mem_addr[11:2]];
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor, sampled mid-cycle after the responder has settled.
  always @(negedge clk) begin : mon
    mem_t e;
    cpu_t c;
    #2;
    if (mem_req && mem_ack) begin
      acks_seen++;
      if (exp_mem.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL mem_unexpected observed=%h expected=none", mem_addr);
      end else begin
        e = exp_mem.pop_front();
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
        if (e.we) chk("mem_wdata", mem_wdata, e.data);
        if (!e.we) begin
          chk("refill_data_we", {31'b0, data_we}, 32'd1);
          chk("refill_data_addr", {26'b0, data_addr}, {26'b0, mem_addr[7:2]});
          chk("refill_data_wdata", data_wdata, mem_rdata);
        end
      end
    end
    if (cpu_ready) begin
      if (exp_cpu.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL cpu_unexpected observed=%h expected=none", cpu_addr);
      end else begin
        c = exp_cpu.pop_front();
        chk("ready_data_we", {31'b0, data_we}, {31'b0, c.dwe});
        if (!c.we) chk("cpu_rdata", cpu_rdata, c.data);
        if (c.dwe) begin
          chk("store_data_addr", {26'b0, data_addr}, {26'b0, c.daddr});
          chk("store_data_wdata", data_wdata, c.data);
        end
      end
    end
  end

  task automatic push_refill(input logic [31:0] addr);
    for (int i = 0; i < 4; i++)
      exp_mem.push_back('{(addr & ~32'hF) + 32'(4 * i), 1'b0, 32'h0});
  endtask

  // One CPU access; `cached` states whether the line is expected present.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit cached, input string tag);
    int n;
    int exp_n;
    @(negedge clk);
    if (we) begin
      exp_mem.push_back('{addr & ~32'h3, 1'b1, wdata});
      exp_cpu.push_back('{1'b1, wdata, cached, addr[7:2]});
      exp_n = lat + 2;
    end else begin
      exp_cpu.push_back('{1'b0, mem_model[addr[11:2]], 1'b0, addr[7:2]});
      if (!cached) push_refill(addr);
      exp_n = cached ? 1 : 4 * (lat + 1) + 2;
    end
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    n = 1;
    #3;
    while (!cpu_ready && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!cpu_ready) begin
      checks++;
      failures++;
      $error("FAIL %s_timeout observed=%0d cycles expected=ready", tag, n);
      exp_mem.delete();
      exp_cpu.delete();
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_n));
    chk({tag, "_mem_left"}, 32'(exp_mem.size()), 32'd0);
    chk({tag, "_cpu_left"}, 32'(exp_cpu.size()), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) darr[i] = '0;
    for (int i = 0; i < 1024; i++) mem_model[i] = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
    mem_model[16] = 32'h11;
    mem_model[17] = 32'h22;
    mem_model[18] = 32'h33;
    mem_model[19] = 32'h44;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    chk("rst_data_we", {31'b0, data_we}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;

    // Refill, hits, store hit and store miss
    lat = 0;
    access(1'b0, 32'h0000_0040, 32'h0, 1'b0, "miss_40");
    access(1'b0, 32'h0000_0048, 32'h0, 1'b1, "hit_48");
    chk("hit_48_value", cpu_rdata, 32'h33);
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b1, "store_hit_44");
    access(1'b0, 32'h0000_0044, 32'h0, 1'b1, "hit_44");
    chk("hit_44_value", cpu_rdata, 32'hDEAD_BEEF);
    lat = 2;
    access(1'b1, 32'h0000_0400, 32'h1234_5678, 1'b0, "store_miss_400");
    lat = 1;
    access(1'b0, 32'h0000_0400, 32'h0, 1'b0, "miss_400");
    chk("miss_400_value", cpu_rdata, 32'h1234_5678);

    // Conflict eviction on index 4
    lat = 0;
    access(1'b0, 32'h0000_0140, 32'h0, 1'b0, "conflict_140");
    access(1'b0, 32'h0000_0040, 32'h0, 1'b0, "evicted_40");
    access(1'b0, 32'h0000_004C, 32'h0, 1'b1, "hit_4c");
    chk("hit_4c_value", cpu_rdata, 32'h44);

    // Reset during a refill aborts it
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    acks_seen = 0;
    push_refill(32'h0000_0200);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0200;
    n = 0;
    #3;
    while (acks_seen < 2 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    rst     = 1'b0;
    cpu_req = 1'b0;
    chk("abort_acks", 32'(acks_seen), 32'd2);
    @(negedge clk);
    #3;
    chk("abort_mem_req", {31'b0, mem_req}, 32'd0);
    chk("abort_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    exp_mem.delete();
    rst = 1'b1;
    access(1'b0, 32'h0000_0200, 32'h0, 1'b0, "reread_200");
    access(1'b0, 32'h0000_0040, 32'h0, 1'b0, "post_rst_40");

`ifdef CACHE_STATS_EN
    @(negedge clk);
    cpu_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    access(1'b0, 32'h0000_0080, 32'h0, 1'b0, "stat_miss");
    access(1'b0, 32'h0000_0084, 32'h0, 1'b1, "stat_hit1");
    access(1'b0, 32'h0000_0088, 32'h0, 1'b1, "stat_hit2");
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    #3;
    chk("miss_count", miss_count, 32'd1);
    chk("hit_count", hit_count, 32'd2);
`endif

    @(negedge clk);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
